// File: rtl/fp_pkg.sv
// Shared constants and types for the binary32 sequential multiplier.
package fp_pkg;

    localparam int BIAS   = 127;
    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;

    localparam logic [EXP_W-1:0]  EXP_INF   = 8'hFF;
    localparam logic [EXP_W-1:0]  EXP_ZERO  = 8'h00;
    localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        NORM   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/mant_mul_seq.sv
// 24x24 -> 48 shift-add mantissa multiplier, one partial product per cycle.
// done is high during the final step; product is complete from the next cycle.
module mant_mul_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic [MANT_W-1:0] mcand;
    logic [MANT_W-1:0] mplier;
    logic [4:0]        cnt;
    logic [PROD_W-1:0] acc;

    always_ff @(negedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[cnt])
                acc <= acc + ({{MANT_W{1'b0}}, mcand} << cnt);
            if (cnt == 5'd23)
                busy <= 1'b0;
            else
                cnt <= cnt + 5'd1;
        end
    end

    assign done    = busy && (cnt == 5'd23);
    assign product = acc;

endmodule

// File: rtl/fp_mul.sv
// IEEE 754 binary32 multiplier: unpack, sequential mantissa multiply, normalise, pack.
// Define FP_MUL_ROUND_EN for round-to-nearest-even in NORM; otherwise dropped bits are truncated.
module fp_mul
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        start,
    output logic [31:0] num_out,
    output logic        done
);

    state_t state, next_state;

    logic              mul_start, mul_busy, mul_done, load_out;
    logic [PROD_W-1:0] product;

    logic              sign_r, zero_r;
    logic signed [9:0] exp_r, exp_n, exp_t, exp_f;
    logic [FRAC_W-1:0] frac_n;
    logic [MANT_W-1:0] mant_t, mant_f;
    logic              unused_bits;

    mant_mul_seq u_mant (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       ({1'b1, num1[FRAC_W-1:0]}),
        .b       ({1'b1, num2[FRAC_W-1:0]}),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(negedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = MULT;
            MULT:    if (mul_done) next_state = NORM;
            NORM:                  next_state = OUTPUT;
            OUTPUT:                next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state == IDLE) && start;
        load_out  = (state == OUTPUT);
    end

    // Leading one sits at bit 47 or 46 of the 1.x * 1.x product.
    always_comb begin
        if (product[PROD_W-1]) begin
            mant_t = product[47:24];
            exp_t  = exp_r + 10'sd1;
        end else begin
            mant_t = product[46:23];
            exp_t  = exp_r;
        end
    end

`ifdef FP_MUL_ROUND_EN
    logic       guard, sticky, carry;
    logic [MANT_W-1:0] mant_r;
    always_comb begin
        guard  = product[PROD_W-1] ? product[23] : product[22];
        sticky = product[PROD_W-1] ? (|product[22:0]) : (|product[21:0]);
        {carry, mant_r} = {1'b0, mant_t} + {{MANT_W{1'b0}}, guard & (sticky | mant_t[0])};
        mant_f = carry ? {1'b1, mant_r[MANT_W-1:1]} : mant_r;
        exp_f  = carry ? exp_t + 10'sd1 : exp_t;
    end
    assign unused_bits = mant_f[MANT_W-1];
`else
    always_comb begin
        mant_f = mant_t;
        exp_f  = exp_t;
    end
    assign unused_bits = mant_f[MANT_W-1] ^ (^product[22:0]);
`endif

    always_ff @(negedge clk) begin
        if (rst) begin
            sign_r  <= 1'b0;
            zero_r  <= 1'b0;
            exp_r   <= '0;
            exp_n   <= '0;
            frac_n  <= '0;
            num_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= load_out;
            if (mul_start) begin
                sign_r <= num1[31] ^ num2[31];
                exp_r  <= $signed({2'b00, num1[30:23]}) + $signed({2'b00, num2[30:23]}) - 10'sd127;
                zero_r <= (num1[30:23] == EXP_ZERO) || (num2[30:23] == EXP_ZERO);
            end
            if (state == NORM) begin
                exp_n  <= exp_f;
                frac_n <= mant_f[FRAC_W-1:0];
            end
            if (load_out) begin
                if (zero_r)
                    num_out <= {sign_r, EXP_ZERO, FRAC_ZERO};
                else if (exp_n > 10'sd254)
                    num_out <= {sign_r, EXP_INF, FRAC_ZERO};
                else if (exp_n < 10'sd1)
                    num_out <= {sign_r, EXP_ZERO, FRAC_ZERO};
                else
                    num_out <= {sign_r, exp_n[EXP_W-1:0], frac_n};
            end
        end
    end

endmodule

// File: doc/fp_mul.md
FP_MUL -- requirements
Module: fp_mul

Interface
REQ-001 SHALL have no parameters; format fixed to IEEE 754 binary32, exponent bias 127.
REQ-002 SHALL have port clk  input  1  single clock; all registers update on the falling edge, matching the downstream adder stage.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port num1  input  32  operand 1, IEEE 754 single.
REQ-005 SHALL have port num2  input  32  operand 2, IEEE 754 single.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port num_out  output  32  product, IEEE 754 single, registered, held until next result.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking num_out valid; drives the adder's start input directly.

Function
REQ-009 SHALL implement states IDLE, MULT, NORM, OUTPUT.
REQ-010 IDLE SHALL drive done=0, and on start=1 go to MULT, capturing:
  - sign = num1[31]^num2[31]
  - exponent = num1[30:23] + num2[30:23] - 127 as a 10-bit signed value
  - mantissas {1,frac}
  - a zero flag if either exponent field is 0
  - 48-bit accumulator = 0; 5-bit counter = 0.
REQ-011 MULT SHALL perform one shift-add step per cycle for 24 cycles: if multiplier bit[cnt] is set, add multiplicand<<cnt; on cnt==23 go to NORM.
REQ-012 NORM SHALL take the mantissa from product[47:24] with exponent+1 if product[47]=1, else from product[46:23]; it SHALL then go to OUTPUT.
REQ-013 OUTPUT SHALL load num_out, assert done=1 for exactly one cycle, and return to IDLE.
REQ-014 Latency SHALL be fixed: start sampled at edge N gives done=1 after edge N+26; throughput is one operation per 27 cycles.
REQ-015 start SHALL be ignored outside IDLE; operands SHALL be captured only at acceptance.
REQ-016 With start held high continuously, a new operation SHALL be accepted in the IDLE cycle right after each OUTPUT.
REQ-017 Zero flag set SHALL force num_out = {sign, 31'b0}, regardless of the other operand.
REQ-018 Final biased exponent > 254 SHALL saturate to {sign, 8'hFF, 23'b0}.
REQ-019 Final biased exponent < 1 SHALL flush to {sign, 31'b0}; subnormals are not produced.
REQ-020 Exponent field 255 on inputs SHALL NOT be special-cased; it is treated as an ordinary value.

Reset
REQ-021 rst=1 SHALL force state=IDLE, done=0, num_out=0, accumulator=0, counter=0 at the next falling edge.
REQ-022 rst during MULT, NORM or OUTPUT SHALL abort the operation with no done pulse; rst has priority over start.

Configuration
REQ-023 With FP_MUL_ROUND_EN defined, NORM SHALL round to nearest-even:
  - guard = first dropped bit; sticky = OR of the remaining dropped bits
  - increment when guard & (sticky | lsb)
  - on mantissa carry-out, shift right once and increment the exponent
  - latency unchanged.
REQ-024 Without FP_MUL_ROUND_EN, NORM SHALL truncate dropped bits.

Structure
REQ-025 A shared package fp_pkg SHALL hold:
  - the bias constant 127
  - field widths (sign 1, exponent 8, fraction 23)
  - the inf and zero field constants
  - the state enumeration typedef.
REQ-026 The shift-add datapath (accumulator, counter, step logic) SHALL be a sub-module mant_mul_seq (24x24 to 48, start/busy/done); fp_mul keeps unpack, normalise and pack.

Verification
REQ-027 0x40000000 x 0x40400000 -> num_out 0x40C00000, done high exactly one cycle, 26 edges after the start edge.
REQ-028 0xC0800000 x 0x3F000000 -> 0xC0000000; 0x3F800000 x 0x3F800000 -> 0x3F800000.
REQ-029 0x3F800001 x 0x3FC00000 -> 0x3FC00002 with FP_MUL_ROUND_EN, 0x3FC00001 without.
REQ-030 0x00000000 x 0x42C80000 -> 0x00000000; 0x80000000 x 0x3F800000 -> 0x80000000.
REQ-031 0x7F000000 x 0x40000000 -> 0x7F800000; 0x00800000 x 0x00800000 -> 0x00000000.
REQ-032 Reset and back-to-back:
  - rst pulsed 10 cycles after start -> no done, num_out 0x00000000
  - start held high over 3 operations -> done pulses 27 cycles apart, with the correct product each.
